// File: rtl/hdmi_timing_pkg.sv
// Shared raster constants, pixel colour type and the colour-bar lookup for the HDMI row fetch path.
package hdmi_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int FETCH_LAT = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Bars run white, yellow, cyan, green, magenta, red, blue, black from the left edge.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        c.r = (idx == 3'd0 || idx == 3'd1 || idx == 3'd4 || idx == 3'd5) ? 8'hFF : 8'h00;
        c.g = (idx == 3'd0 || idx == 3'd1 || idx == 3'd2 || idx == 3'd3) ? 8'hFF : 8'h00;
        c.b = (idx == 3'd0 || idx == 3'd2 || idx == 3'd4 || idx == 3'd6) ? 8'hFF : 8'h00;
        return c;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters with raw active/sync flags and the row-buffer swap point decode.
module video_timing_gen
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] h,
    output logic       active,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       swap_pt,
    output logic [7:0] vis_row
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [9:0] v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= 10'd0;
            v <= 10'd0;
        end else if (h == 10'(H_TOT - 1)) begin
            h <= 10'd0;
            v <= (v == 10'(V_TOT - 1)) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    // Each odd line exposes the next PPU row; the last frame line brings row 0 back for the next frame.
    always_comb begin
        active  = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
        hsync_n = !((h >= 10'(H_ACTIVE + H_FP)) && (h < 10'(H_ACTIVE + H_FP + H_SYNC)));
        vsync_n = !((v >= 10'(V_ACTIVE + V_FP)) && (v < 10'(V_ACTIVE + V_FP + V_SYNC)));
        swap_pt = (h == 10'(H_ACTIVE)) &&
                  ((v[0] && (v < 10'(V_ACTIVE - 1))) || (v == 10'(V_TOT - 1)));
        vis_row = (v == 10'(V_TOT - 1)) ? 8'd0 : 8'(v[9:1]) + 8'd1;
    end

endmodule

// File: rtl/hdmi_row_fetch.sv
// Reads the visible PPU row through the palette RAM and drives registered RGB, syncs and DE to HDMI.
// Build macro HDMI_TEST_PATTERN_EN adds a test_pattern input that replaces palette colour with 8 bars.
module hdmi_row_fetch
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
`ifdef HDMI_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    input  logic        clk,
    input  logic        rst,
    output logic [8:0]  hdmi_rowram_rdaddr,
    input  logic [9:0]  hdmi_rowram_rddata,
    output logic [8:0]  hdmi_palram_rdaddr,
    input  logic [63:0] hdmi_palram_rddata,
    output logic        rowram_swap,
    output logic [7:0]  next_row,
    output logic [7:0]  vid_r,
    output logic [7:0]  vid_g,
    output logic [7:0]  vid_b,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        vid_de
);

    localparam int ROWS = V_ACTIVE / 2;
    localparam int DLY  = FETCH_LAT - 1;

    logic [9:0]     h;
    logic           active;
    logic           hsync_n;
    logic           vsync_n;
    logic           swap_pt;
    logic [7:0]     vis_row;
    logic [DLY-1:0] act_d;
    logic [DLY-1:0] hs_d;
    logic [DLY-1:0] vs_d;
    logic           w0_q;
    rgb_t           pix;
    logic           unused_bits;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk     (clk),
        .rst     (rst),
        .h       (h),
        .active  (active),
        .hsync_n (hsync_n),
        .vsync_n (vsync_n),
        .swap_pt (swap_pt),
        .vis_row (vis_row)
    );

    // Row words fetched during blanking are discarded by forcing palette address 0.
    assign hdmi_rowram_rdaddr = h[9:1];
    assign hdmi_palram_rdaddr = act_d[0] ? hdmi_rowram_rddata[9:1] : 9'd0;
    assign rowram_swap        = swap_pt;
    assign unused_bits        = ^{h[0], hdmi_palram_rddata[63:56], hdmi_palram_rddata[31:24]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_d <= '0;
            hs_d  <= '1;
            vs_d  <= '1;
            w0_q  <= 1'b0;
        end else begin
            act_d <= {act_d[DLY-2:0], active};
            hs_d  <= {hs_d[DLY-2:0], hsync_n};
            vs_d  <= {vs_d[DLY-2:0], vsync_n};
            w0_q  <= hdmi_rowram_rddata[0];
        end
    end

`ifdef HDMI_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_s1;
    logic [2:0] bar_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_s1 <= 3'd0;
            bar_s2 <= 3'd0;
        end else begin
            bar_s1 <= 3'(h / 10'(BAR_W));
            bar_s2 <= bar_s1;
        end
    end
`endif

    always_comb begin
        pix = w0_q ? rgb_t'(hdmi_palram_rddata[55:32]) : rgb_t'(hdmi_palram_rddata[23:0]);
`ifdef HDMI_TEST_PATTERN_EN
        if (test_pattern) begin
            pix = bar_colour(bar_s2);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_de    <= 1'b0;
            vid_hsync <= 1'b1;
            vid_vsync <= 1'b1;
            vid_r     <= 8'd0;
            vid_g     <= 8'd0;
            vid_b     <= 8'd0;
        end else begin
            vid_de    <= act_d[DLY-1];
            vid_hsync <= hs_d[DLY-1];
            vid_vsync <= vs_d[DLY-1];
            vid_r     <= act_d[DLY-1] ? pix.r : 8'd0;
            vid_g     <= act_d[DLY-1] ? pix.g : 8'd0;
            vid_b     <= act_d[DLY-1] ? pix.b : 8'd0;
        end
    end

    // next_row names the row the mixer renders into the buffer just released by the swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_row <= 8'd0;
        end else if (swap_pt) begin
            next_row <= (vis_row == 8'(ROWS - 1)) ? 8'd0 : vis_row + 8'd1;
        end
    end

endmodule

// File: tb/tb_hdmi_row_fetch.sv
// Self-checking bench: a shrunk raster instance runs whole frames, a default instance checks real line timing.
module tb_hdmi_row_fetch;
    import hdmi_timing_pkg::*;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } cfg_t;

    localparam cfg_t SMALL = '{64, 4, 8, 4, 20, 2, 2, 2};
    localparam cfg_t FULL  = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam int S_HT    = 80;
    localparam int S_FRAME = 80 * 26;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tp  = 1'b0;

    always #5 clk = ~clk;

    logic [8:0]  s_row_addr, f_row_addr, s_pal_addr, f_pal_addr;
    logic [9:0]  s_row_rd, f_row_rd;
    logic [63:0] s_pal_rd, f_pal_rd;
    logic        s_swap, f_swap, s_hs, f_hs, s_vs, f_vs, s_de, f_de;
    logic [7:0]  s_nrow, f_nrow, s_r, s_g, s_b, f_r, f_g, f_b;

    logic [9:0]  s_rowmem [512];
    logic [63:0] s_palmem [512];
    logic [9:0]  f_rowmem [512];
    logic [63:0] f_palmem [512];
    logic [23:0] bar_tab  [8];

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;
    int phase       = 0;
    int exp_nr   [2];
    int swap_cnt [2];

    always @(posedge clk) begin
        s_row_rd <= s_rowmem[s_row_addr];
        s_pal_rd <= s_palmem[s_pal_addr];
        f_row_rd <= f_rowmem[f_row_addr];
        f_pal_rd <= f_palmem[f_pal_addr];
    end

    hdmi_row_fetch #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_small (
`ifdef HDMI_TEST_PATTERN_EN
        .test_pattern       (tp),
`endif
        .clk                (clk),
        .rst                (rst),
        .hdmi_rowram_rdaddr (s_row_addr),
        .hdmi_rowram_rddata (s_row_rd),
        .hdmi_palram_rdaddr (s_pal_addr),
        .hdmi_palram_rddata (s_pal_rd),
        .rowram_swap        (s_swap),
        .next_row           (s_nrow),
        .vid_r              (s_r),
        .vid_g              (s_g),
        .vid_b              (s_b),
        .vid_hsync          (s_hs),
        .vid_vsync          (s_vs),
        .vid_de             (s_de)
    );

    hdmi_row_fetch dut_full (
`ifdef HDMI_TEST_PATTERN_EN
        .test_pattern       (1'b0),
`endif
        .clk                (clk),
        .rst                (rst),
        .hdmi_rowram_rdaddr (f_row_addr),
        .hdmi_rowram_rddata (f_row_rd),
        .hdmi_palram_rdaddr (f_pal_addr),
        .hdmi_palram_rddata (f_pal_rd),
        .rowram_swap        (f_swap),
        .next_row           (f_nrow),
        .vid_r              (f_r),
        .vid_g              (f_g),
        .vid_b              (f_b),
        .vid_hsync          (f_hs),
        .vid_vsync          (f_vs),
        .vid_de             (f_de)
    );

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s at n=%0d: observed %0h, expected %0h", tag, n, obs, expv);
        end
    endtask

    function automatic logic [9:0] row_word(input int id, input int x);
        return (id == 0) ? s_rowmem[x] : f_rowmem[x];
    endfunction

    function automatic logic [63:0] pal_word(input int id, input int a);
        return (id == 0) ? s_palmem[a] : f_palmem[a];
    endfunction

    // Colour shown for output column x, straight from the RAM contents.
    function automatic logic [23:0] model_colour(input int id, input int x);
        logic [9:0]  w;
        logic [63:0] word;
        w    = row_word(id, x / 2);
        word = pal_word(id, int'(w[9:1]));
        if (id == 0 && tp) return bar_tab[x / (SMALL.ha / 8)];
        return w[0] ? word[55:32] : word[23:0];
    endfunction

    task automatic check_cycle(input int id, input string nm,
                               input logic [8:0] rdaddr, input logic swp, input logic [7:0] nrow,
                               input logic [8:0] paddr, input logic de, input logic hs,
                               input logic vs, input logic [23:0] rgb);
        cfg_t c;
        int   ht, vt, h, v, m, hm, vm;
        logic sw, act;
        logic [9:0] w;
        c  = (id == 0) ? SMALL : FULL;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        h  = n % ht;
        v  = (n / ht) % vt;
        check_output({nm, " rdaddr"}, 64'(rdaddr), 64'(h / 2));
        sw = (h == c.ha) && ((((v % 2) == 1) && (v < c.va - 1)) || (v == vt - 1));
        check_output({nm, " swap"}, 64'(swp), 64'(sw));
        check_output({nm, " next_row"}, 64'(nrow), 64'(exp_nr[id]));
        if (sw) begin
            swap_cnt[id]++;
            exp_nr[id] = (((v == vt - 1) ? 0 : (v + 1) / 2) + 1) % (c.va / 2);
        end
        if (h == ht - 1 && v == vt - 1) begin
            check_output({nm, " swaps/frame"}, 64'(swap_cnt[id]), 64'(c.va / 2));
            swap_cnt[id] = 0;
        end
        if (n >= 1) begin
            m   = n - 1;
            hm  = m % ht;
            vm  = (m / ht) % vt;
            act = (hm < c.ha) && (vm < c.va);
            w   = row_word(id, hm / 2);
            check_output({nm, " paladdr"}, 64'(paddr), act ? 64'(w[9:1]) : 64'd0);
        end
        if (n >= FETCH_LAT) begin
            m   = n - FETCH_LAT;
            hm  = m % ht;
            vm  = (m / ht) % vt;
            act = (hm < c.ha) && (vm < c.va);
            check_output({nm, " de"}, 64'(de), 64'(act));
            check_output({nm, " hsync"}, 64'(hs),
                         64'(!(hm >= c.ha + c.hf && hm < c.ha + c.hf + c.hs)));
            check_output({nm, " vsync"}, 64'(vs),
                         64'(!(vm >= c.va + c.vf && vm < c.va + c.vf + c.vs)));
            check_output({nm, " rgb"}, 64'(rgb), act ? 64'(model_colour(id, hm)) : 64'd0);
        end else begin
            check_output({nm, " de"}, 64'(de), 64'd0);
            check_output({nm, " hsync"}, 64'(hs), 64'd1);
            check_output({nm, " vsync"}, 64'(vs), 64'd1);
            check_output({nm, " rgb"}, 64'(rgb), 64'd0);
        end
    endtask

    task automatic check_reset(input string nm, input logic [8:0] rdaddr, input logic swp,
                               input logic [7:0] nrow, input logic [8:0] paddr, input logic de,
                               input logic hs, input logic vs, input logic [23:0] rgb);
        check_output({nm, " rst rdaddr"}, 64'(rdaddr), 64'd0);
        check_output({nm, " rst swap"}, 64'(swp), 64'd0);
        check_output({nm, " rst next_row"}, 64'(nrow), 64'd0);
        check_output({nm, " rst paladdr"}, 64'(paddr), 64'd0);
        check_output({nm, " rst de"}, 64'(de), 64'd0);
        check_output({nm, " rst hsync"}, 64'(hs), 64'd1);
        check_output({nm, " rst vsync"}, 64'(vs), 64'd1);
        check_output({nm, " rst rgb"}, 64'(rgb), 64'd0);
    endtask

    task automatic check_both_reset();
        check_reset("small", s_row_addr, s_swap, s_nrow, s_pal_addr, s_de, s_hs, s_vs, {s_r, s_g, s_b});
        check_reset("full", f_row_addr, f_swap, f_nrow, f_pal_addr, f_de, f_hs, f_vs, {f_r, f_g, f_b});
        exp_nr[0] = 0; exp_nr[1] = 0; swap_cnt[0] = 0; swap_cnt[1] = 0;
    endtask

    // Next frame's row contents: phase 1 all 0x002, later phases random; bars during phase 2.
    task automatic apply_stimulus(input int p);
        for (int i = 0; i < 512; i++) begin
            s_rowmem[i] = (p == 1) ? 10'h002 : 10'($urandom);
        end
`ifdef HDMI_TEST_PATTERN_EN
        tp = (p == 2);
`endif
    endtask

    task automatic run_cycles(input int count);
        for (int k = 0; k < count; k++) begin
            check_cycle(0, "small", s_row_addr, s_swap, s_nrow, s_pal_addr, s_de, s_hs, s_vs, {s_r, s_g, s_b});
            check_cycle(1, "full", f_row_addr, f_swap, f_nrow, f_pal_addr, f_de, f_hs, f_vs, {f_r, f_g, f_b});
            if ((n % S_HT) == 0 && ((n / S_HT) % 26) == SMALL.va + 1) begin
                phase++;
                apply_stimulus(phase);
            end
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        for (int i = 0; i < 512; i++) begin
            s_rowmem[i] = 10'h003;
            s_palmem[i] = {$urandom, $urandom};
            f_rowmem[i] = 10'($urandom);
            f_palmem[i] = {$urandom, $urandom};
        end
        s_palmem[1] = 64'h00ABCDEF_00123456;

        repeat (3) @(negedge clk);
        #1;
        check_both_reset();
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
        run_cycles(4 * S_FRAME + 8 * S_HT + 30);

        rst = 1'b1;
        #1;
        check_both_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n   = 0;
        run_cycles(2 * S_FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
